ysyx_23060187_wbu: RTL and testbench
====================================

# ysyx_23060187_wbu

Writeback unit for the NPC core: the write-side initiator that drives the general-purpose register file's single write port (wen/waddr/wdata). It accepts completed results from the EXU (ALU results) and LSU (raw load words) over valid/ready channels, and arbitrates between them round-robin. It sign- or zero-extends load data and issues at most one registered write per cycle. It also maintains the retired-instruction counter.

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, data width; fixed at 32 for the load extension logic
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- exu_valid  input  1  EXU result available
- exu_ready  output  1  EXU result accepted this cycle
- exu_rd  input  ADDR_WIDTH  destination register
- exu_data  input  DATA_WIDTH  result value
- lsu_valid  input  1  LSU load result available
- lsu_ready  output  1  LSU result accepted this cycle
- lsu_rd  input  ADDR_WIDTH  destination register
- lsu_rdata  input  DATA_WIDTH  raw aligned bus word
- lsu_addr_lo  input  2  byte offset of the load address
- lsu_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- lsu_unsigned  input  1  1 = zero-extend, 0 = sign-extend
- rf_wen  output  1  register file write enable
- rf_waddr  output  ADDR_WIDTH  register file write address
- rf_wdata  output  DATA_WIDTH  register file write data
- instret  output  64  retired-result count

## Operation
- Handshake: a transfer occurs on a channel when valid && ready at a rising edge.
- Producers hold valid and the payload stable until the transfer. Valid must not depend on ready.
- Grant (combinational):
  - Only one channel valid: that channel is granted.
  - Both valid: grant the channel not granted in the most recent transfer (last_grant). A transfer on either channel updates last_grant.
  - Neither valid: no grant.
- Ready: each channel's ready equals its grant. The register file never back-pressures, so ready is never withheld for any other reason. At most one ready is high per cycle.
- Load extension, applied to the LSU payload only:
  - Byte: selected byte = lsu_rdata[8*addr_lo +: 8].
  - Half: addr_lo[1] selects the upper 16 bits; addr_lo[0] is ignored (misaligned halves are not trapped here).
  - Word: addr_lo is ignored.
  - Byte and half are extended to 32 bits by bit 7 / bit 15, or by zero when lsu_unsigned = 1.
- EXU data passes through unmodified.
- Output register, updated every cycle:
  - On a transfer: rf_waddr and rf_wdata take the granted rd and the (extended) data. rf_wen = 1 if rd != 0, else 0.
  - Without a transfer: rf_wen = 0. rf_waddr and rf_wdata hold their previous values.
- instret increments by 1 on every transfer, including transfers with rd = 0. It wraps modulo 2^64.

## Timing
- Reset values: rf_wen = 0, rf_waddr = 0, rf_wdata = 0, instret = 0, last_grant = LSU. The first tie therefore grants the EXU.
- Reset is asynchronous: asserting rst_n mid-stream clears all state immediately. A write already presented on rf_wen is dropped. While rst_n = 0, exu_ready and lsu_ready are 0.
- Latency: a transfer at edge N puts rf_wen/waddr/wdata valid during cycle N+1. The register file commits the value at edge N+1. instret reflects the transfer from cycle N+1.
- Throughput: one transfer per cycle. With both channels valid continuously, grants alternate every cycle.
- rf_wen is never high for more than one cycle per transfer. Back-to-back transfers to the same rd produce back-to-back writes in transfer order.
- Forwarding or bypass of in-flight writes is the consumer's responsibility. The value is readable from the register file from cycle N+2.

## Test plan
- Reset, then a single EXU transfer (rd = 5, data = 0xDEADBEEF): exu_ready = 1 in cycle 0; in cycle 1 rf_wen = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF; in cycle 2 rf_wen = 0; instret = 1.
- Both channels valid for 4 cycles: grant order EXU, LSU, EXU, LSU; exactly one ready per cycle; instret = 4.
- LSU loads of lsu_rdata = 0x80FF7F01 (rd = 3), each -> rf_wdata:
  - byte, offset 2, signed -> 0xFFFFFFFF
  - byte, offset 3, unsigned -> 0x00000080
  - half, offset 2, signed -> 0xFFFF80FF
  - half, offset 0, unsigned -> 0x00007F01
  - word -> 0x80FF7F01
  - size 11 -> 0x80FF7F01
- EXU transfer with rd = 0, data = 0x1234: handshake completes, rf_wen stays 0, instret increments.
- rst_n asserted low in the cycle after a transfer: rf_wen drops to 0 immediately and instret = 0. After release, the next tie grants the EXU.
- Both channels idle for 3 cycles: rf_wen = 0, rf_waddr and rf_wdata hold their last values, instret unchanged.

Source files
------------

// File: rtl/ysyx_23060187_wbu.sv
// ysyx_23060187_wbu: round-robin EXU/LSU writeback into the register file write port, with load extension and retire counter
module ysyx_23060187_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic [1:0]            lsu_addr_lo,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [63:0]           instret
);
  logic                  last_lsu;
  logic                  gnt_exu;
  logic                  gnt_lsu;
  logic [DATA_WIDTH-1:0] shifted;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [ADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_data;
  always_comb begin
    gnt_exu = rst_n && exu_valid && (!lsu_valid || last_lsu);
    gnt_lsu = rst_n && lsu_valid && (!exu_valid || !last_lsu);
    shifted = lsu_rdata >> {lsu_addr_lo, 3'b000};
    ld_b    = shifted[7:0];
    ld_h    = lsu_addr_lo[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
    ld_data = lsu_size == 2'b00 ? {{(DATA_WIDTH-8){~lsu_unsigned & ld_b[7]}}, ld_b} :
              lsu_size == 2'b01 ? {{(DATA_WIDTH-16){~lsu_unsigned & ld_h[15]}}, ld_h} :
              lsu_rdata;
    w_rd    = gnt_lsu ? lsu_rd : exu_rd;
    w_data  = gnt_lsu ? ld_data : exu_data;
  end
  assign exu_ready = gnt_exu;
  assign lsu_ready = gnt_lsu;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      instret  <= '0;
      last_lsu <= 1'b1;
    end else begin
      rf_wen <= (gnt_exu || gnt_lsu) && (w_rd != '0);
      if (gnt_exu || gnt_lsu) begin
        rf_waddr <= w_rd;
        rf_wdata <= w_data;
        instret  <= instret + 64'd1;
        last_lsu <= gnt_lsu;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_23060187_wbu.sv
// tb_ysyx_23060187_wbu: directed scoreboard bench for the writeback unit
module tb_ysyx_23060187_wbu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_valid, exu_ready, lsu_valid, lsu_ready, lsu_unsigned, rf_wen;
  logic [4:0]  exu_rd, lsu_rd, rf_waddr;
  logic [31:0] exu_data, lsu_rdata, rf_wdata;
  logic [1:0]  lsu_addr_lo, lsu_size;
  logic [63:0] instret;
  typedef struct packed {
    logic        wen;
    logic [4:0]  a;
    logic [31:0] d;
    logic [63:0] n;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic        last_lsu_m;
  logic [4:0]  waddr_m;
  logic [31:0] wdata_m;
  logic [63:0] instret_m;
  always #5 clk = ~clk;
  ysyx_23060187_wbu dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_addr_lo(lsu_addr_lo), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .instret(instret)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    last_lsu_m = 1'b1;
    waddr_m    = '0;
    wdata_m    = '0;
    instret_m  = '0;
    sb.delete();
  endtask
  task automatic cyc(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] lrdata,
                     input logic [1:0] lo, input logic [1:0] sz, input logic uns,
                     input logic [31:0] lexp);
    logic ge, gl;
    exp_t e;
    exu_valid = ev; exu_rd = erd; exu_data = ed;
    lsu_valid = lv; lsu_rd = lrd; lsu_rdata = lrdata;
    lsu_addr_lo = lo; lsu_size = sz; lsu_unsigned = uns;
    #1;
    ge = ev && (!lv || last_lsu_m);
    gl = lv && (!ev || !last_lsu_m);
    chk("exu_ready", {63'd0, exu_ready}, {63'd0, ge});
    chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, gl});
    if (ge || gl) begin
      waddr_m    = gl ? lrd : erd;
      wdata_m    = gl ? lexp : ed;
      instret_m  = instret_m + 64'd1;
      last_lsu_m = gl;
      sb.push_back('{waddr_m != 5'd0, waddr_m, wdata_m, instret_m});
    end else
      sb.push_back('{1'b0, waddr_m, wdata_m, instret_m});
    @(negedge clk);
    e = sb.pop_front();
    chk("rf_wen", {63'd0, rf_wen}, {63'd0, e.wen});
    chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.a});
    chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.d});
    chk("instret", instret, e.n);
  endtask
  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0);
  endtask
  task automatic ld(input logic [1:0] lo, input logic [1:0] sz, input logic uns, input logic [31:0] lexp);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h80FF7F01, lo, sz, uns, lexp);
  endtask
  initial begin
    rst_n = 1'b0;
    exu_valid = 1'b1; lsu_valid = 1'b1;
    exu_rd = '0; exu_data = '0; lsu_rd = '0; lsu_rdata = '0;
    lsu_addr_lo = '0; lsu_size = '0; lsu_unsigned = 1'b0;
    model_reset();
    #1;
    chk("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_rf_wdata", {32'd0, rf_wdata}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_exu_ready", {63'd0, exu_ready}, 64'd0);
    chk("rst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
    @(negedge clk);
    exu_valid = 1'b0; lsu_valid = 1'b0;
    rst_n = 1'b1;
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0);
    idle();
    ld(2'd2, 2'b00, 1'b0, 32'hFFFFFFFF);
    ld(2'd3, 2'b00, 1'b1, 32'h00000080);
    ld(2'd2, 2'b01, 1'b0, 32'hFFFF80FF);
    ld(2'd0, 2'b01, 1'b1, 32'h00007F01);
    ld(2'd1, 2'b10, 1'b0, 32'h80FF7F01);
    ld(2'd3, 2'b11, 1'b0, 32'h80FF7F01);
    ld(2'd1, 2'b00, 1'b0, 32'h0000007F);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b1, 5'(20 + i), 32'hB0 + 32'(i), 2'd0, 2'b10, 1'b0, 32'hB0 + 32'(i));
    chk("tie_instret", instret, 64'd12);
    cyc(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0);
    repeat (3) idle();
    cyc(1'b1, 5'd7, 32'h5555AAAA, 1'b0, 5'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0);
    exu_valid = 1'b1; lsu_valid = 1'b1; lsu_size = 2'b10; lsu_rd = 5'd9;
    rst_n = 1'b0;
    #1;
    chk("async_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("async_instret", instret, 64'd0);
    chk("async_exu_ready", {63'd0, exu_ready}, 64'd0);
    chk("async_lsu_ready", {63'd0, lsu_ready}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 5'd4, 32'hC0FFEE00, 1'b1, 5'd9, 32'h11112222, 2'd0, 2'b10, 1'b0, 32'h11112222);
    cyc(1'b1, 5'd4, 32'hC0FFEE01, 1'b1, 5'd9, 32'h11112222, 2'd0, 2'b10, 1'b0, 32'h11112222);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
